// File: rtl/f_pc_gen_if.sv
// Instruction-memory fetch port between the PC generator and imem.
// Handshake: imem_req is held high with a stable imem_addr until the cycle
// imem_ack is sampled high; that cycle completes the fetch of imem_addr.
// The memory may only assert imem_ack while imem_req is high.
interface f_pc_gen_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/f_pc_gen.sv
// Fetch-stage PC generator for the 5-stage MIPS pipeline.
// Holds the fetch PC, drives the imem request port and picks the next PC
// from sequential flow, D-stage redirects, exception entry and eret.
// A redirect arriving while the delay-slot fetch still waits on memory is
// parked in pend_tgt (state PEND) and applied when that fetch completes.
module f_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        F_stall,
  f_pc_gen_if.master  imem,
  output logic [31:0] F_pc,
  output logic        F_valid,
  output logic        F_adel,
  input  logic        D_valid,
  input  logic [31:0] D_pc,
  input  logic [31:0] D_immExt,
  input  logic [25:0] D_instrIndex,
  input  logic [31:0] D_regJr,
  input  logic        D_branch,
  input  logic        D_B_judge,
  input  logic        D_jump,
  input  logic        D_jr,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic        fd;
  logic        redir_en;
  logic [31:0] redir_tgt;
  logic        req;
  logic        adel;

  // State register: fetch PC, parked redirect target and FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pend_tgt_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Redirect decode: a stalled D re-presents its redirect, so it only counts unstalled.
  always_comb begin
    redir_en  = D_valid & ~F_stall & (D_jr | D_jump | (D_branch & D_B_judge));
    redir_tgt = D_pc + 32'd4 + {D_immExt[29:0], 2'b00};
    if (D_jr) begin
      redir_tgt = D_regJr;
    end else if (D_jump) begin
      redir_tgt = {D_pc[31:28], D_instrIndex, 2'b00};
    end
  end

  // Next-state logic: exception > eret > stall > redirect/pending > sequential.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    if (exc_req) begin
      pc_d    = EXC_VEC;
      state_d = RUN;
    end else if (eret) begin
      pc_d    = epc;
      state_d = RUN;
    end else if (!F_stall) begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (redir_en) begin
            if (fd) begin
              pc_d = redir_tgt;
            end else begin
              pend_tgt_d = redir_tgt;
              state_d    = PEND;
            end
          end else if (fd) begin
            pc_d = pc_q + 32'd4;
          end
        end
        PEND: begin
          // A redirect here should not happen (D holds a bubble); if it does, it wins.
          if (redir_en) begin
            pend_tgt_d = redir_tgt;
          end
          if (fd) begin
            pc_d    = redir_en ? redir_tgt : pend_tgt_q;
            state_d = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  // Outputs: a misaligned PC issues no request and completes at once as a faulting slot.
  always_comb begin
    adel    = (pc_q[1:0] != 2'b00) & (state_q != BOOT);
    req     = (state_q != BOOT) & ~adel;
    fd      = (imem.imem_ack & req) | adel;
    F_valid = fd & ~F_stall;
  end

  assign F_adel         = adel;
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign F_pc           = pc_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_f_pc_gen.sv
// Directed bench for f_pc_gen: expected next PC/state pushed when a cycle is
// driven, popped and compared one cycle later; combinational outputs checked in-cycle.
module tb_f_pc_gen;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic        clk;
  logic        reset;
  logic        F_stall;
  logic [31:0] F_pc;
  logic        F_valid;
  logic        F_adel;
  logic        D_valid;
  logic [31:0] D_pc;
  logic [31:0] D_immExt;
  logic [25:0] D_instrIndex;
  logic [31:0] D_regJr;
  logic        D_branch;
  logic        D_B_judge;
  logic        D_jump;
  logic        D_jr;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [1:0]  dbg_state;

  f_pc_gen_if imem_bus ();

  f_pc_gen dut (
    .clk          (clk),
    .reset        (reset),
    .F_stall      (F_stall),
    .imem         (imem_bus.master),
    .F_pc         (F_pc),
    .F_valid      (F_valid),
    .F_adel       (F_adel),
    .D_valid      (D_valid),
    .D_pc         (D_pc),
    .D_immExt     (D_immExt),
    .D_instrIndex (D_instrIndex),
    .D_regJr      (D_regJr),
    .D_branch     (D_branch),
    .D_B_judge    (D_B_judge),
    .D_jump       (D_jump),
    .D_jr         (D_jr),
    .exc_req      (exc_req),
    .eret         (eret),
    .epc          (epc),
    .dbg_state    (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  exp_st_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Combinational outputs for the cycle currently being driven.
  task automatic chk_out(input string tag, input logic req, input logic vld, input logic adl);
    #1;
    chk({tag, ".req"},   {31'd0, imem_bus.imem_req}, {31'd0, req});
    chk({tag, ".valid"}, {31'd0, F_valid},           {31'd0, vld});
    chk({tag, ".adel"},  {31'd0, F_adel},            {31'd0, adl});
    chk({tag, ".addr"},  imem_bus.imem_addr,          F_pc);
  endtask

  // Push expectation, clock once, pop and compare PC/state.
  task automatic tick(input string tag, input logic [31:0] pc, input logic [1:0] st);
    logic [31:0] e_pc;
    logic [1:0]  e_st;
    exp_q.push_back(pc);
    exp_st_q.push_back(st);
    @(posedge clk);
    #1;
    e_pc = exp_q.pop_front();
    e_st = exp_st_q.pop_front();
    chk({tag, ".pc"},    F_pc,               e_pc);
    chk({tag, ".state"}, {30'd0, dbg_state}, {30'd0, e_st});
  endtask

  task automatic d_clear();
    D_valid = 0; D_branch = 0; D_B_judge = 0; D_jump = 0; D_jr = 0;
    D_pc = 0; D_immExt = 0; D_instrIndex = 0; D_regJr = 0;
  endtask

  initial begin
    int n;
    reset = 1; F_stall = 0; imem_bus.imem_ack = 0; exc_req = 0; eret = 0; epc = 0;
    d_clear();
    @(posedge clk); #1;

    // T1: reset state, BOOT one cycle, then sequential fetches
    chk_out("boot", 0, 0, 0);
    reset = 0; imem_bus.imem_ack = 1;   // ack in BOOT must be ignored
    chk_out("boot_ack", 0, 0, 0);
    tick("boot_exit", 32'h3000, S_RUN);
    chk_out("seq0", 1, 1, 0);
    tick("seq0", 32'h3004, S_RUN);
    tick("seq1", 32'h3008, S_RUN);

    // T2: taken beq at 3004, delay slot 3008 fetched now -> 3048
    D_valid = 1; D_branch = 1; D_B_judge = 1; D_pc = 32'h3004; D_immExt = 32'h10;
    chk_out("beq", 1, 1, 0);
    tick("beq", 32'h3048, S_RUN);
    // Not-taken branch -> sequential
    D_B_judge = 0; D_pc = 32'h3044;
    tick("bne_nt", 32'h304C, S_RUN);
    d_clear();

    // T3: jal while ack low -> PEND, hold for a random number of cycles
    D_valid = 1; D_jump = 1; D_pc = 32'h304C; D_instrIndex = 26'h0000C10;
    imem_bus.imem_ack = 0;
    chk_out("jal_wait", 1, 0, 0);
    tick("jal_wait", 32'h304C, S_PEND);
    d_clear();
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      tick("pend_hold", 32'h304C, S_PEND);
    end
    imem_bus.imem_ack = 1;
    tick("pend_done", 32'h3040, S_RUN);

    // T4: stall with jr pending in D holds; release -> 3100. jr beats jump.
    F_stall = 1;
    D_valid = 1; D_jr = 1; D_jump = 1; D_regJr = 32'h3100; D_pc = 32'h303C; D_instrIndex = 26'h1;
    chk_out("stall", 1, 0, 0);
    tick("stall", 32'h3040, S_RUN);
    F_stall = 0;
    tick("jr", 32'h3100, S_RUN);

    // T5: enter PEND, then exc with eret/redirect/stall -> 4180; eret -> 3010
    D_jump = 0; D_regJr = 32'h3200; imem_bus.imem_ack = 0;
    tick("jr_pend", 32'h3100, S_PEND);
    exc_req = 1; eret = 1; F_stall = 1; epc = 32'h3010;
    tick("exc_prio", 32'h4180, S_RUN);
    exc_req = 0; F_stall = 0; d_clear();
    tick("eret", 32'h3010, S_RUN);
    eret = 0; imem_bus.imem_ack = 1;
    tick("pend_dropped", 32'h3014, S_RUN);

    // T6: jr to misaligned 3102 -> AdEL slots until exception
    D_valid = 1; D_jr = 1; D_regJr = 32'h3102;
    tick("jr_mis", 32'h3102, S_RUN);
    d_clear(); imem_bus.imem_ack = 0;
    chk_out("adel0", 0, 1, 1);
    tick("adel0", 32'h3106, S_RUN);
    chk_out("adel1", 0, 1, 1);
    tick("adel1", 32'h310A, S_RUN);
    exc_req = 1;
    tick("adel_exc", 32'h4180, S_RUN);
    exc_req = 0;

    // Wrap FFFF_FFFC -> 0
    eret = 1; epc = 32'hFFFF_FFFC;
    tick("eret_top", 32'hFFFF_FFFC, S_RUN);
    eret = 0; imem_bus.imem_ack = 1;
    tick("wrap", 32'h0000_0000, S_RUN);

    // Reset while in PEND -> BOOT, RESET_PC, pending lost
    D_valid = 1; D_jr = 1; D_regJr = 32'h5000; imem_bus.imem_ack = 0;
    tick("pend_again", 32'h0000_0000, S_PEND);
    d_clear(); reset = 1;
    tick("reset_pend", 32'h3000, S_BOOT);
    reset = 0; imem_bus.imem_ack = 1;
    tick("boot2", 32'h3000, S_RUN);
    tick("seq_after_rst", 32'h3004, S_RUN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
